// File: rtl/ahb_mem_port_arbiter_pkg.sv
// Shared AHB-Lite codes and owner encodings for the fetch/LSU memory-port arbiter.
package ahb_mem_port_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } master_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_arb_starve_cnt.sv
// Counts LSU address phases won while fetch waits; forces fetch through at STARVE_MAX.
module ahb_arb_starve_cnt
  import ahb_mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             acc_i,
  input  logic             acc_d,
  output logic             force_i,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req_i || acc_i) begin
      starve_cnt <= '0;
    end else if (acc_d && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_i = req_i && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/ahb_mem_port_arbiter.sv
// Two-master (fetch, LSU) to one-slave AHB-Lite arbiter with zero added latency.
// Address-phase grant and data-phase ownership are tracked separately so pipelining is preserved.
module ahb_mem_port_arbiter
  import ahb_mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] i_haddr,
  input  logic [1:0]    i_htrans,
  input  logic [2:0]    i_hsize,
  input  logic [2:0]    i_hburst,
  input  logic [3:0]    i_hprot,
  output logic [DW-1:0] i_hrdata,
  output logic          i_hready,
  output logic          i_hresp,

  input  logic [AW-1:0] d_haddr,
  input  logic [1:0]    d_htrans,
  input  logic          d_hwrite,
  input  logic [2:0]    d_hsize,
  input  logic [2:0]    d_hburst,
  input  logic [3:0]    d_hprot,
  input  logic [DW-1:0] d_hwdata,
  output logic [DW-1:0] d_hrdata,
  output logic          d_hready,
  output logic          d_hresp,

  output logic [AW-1:0] m_haddr,
  output logic [1:0]    m_htrans,
  output logic          m_hwrite,
  output logic [2:0]    m_hsize,
  output logic [2:0]    m_hburst,
  output logic [3:0]    m_hprot,
  output logic [DW-1:0] m_hwdata,
  input  logic [DW-1:0] m_hrdata,
  input  logic          m_hready,
  input  logic          m_hresp,
  output logic          m_hmaster
);

  logic       req_i;
  logic       req_d;
  master_e    gnt;
  master_e    park_q;
  logic       lock_q;
  owner_e     dp_owner;
  logic       gnt_i;
  logic       gnt_d;
  logic       gnt_act;
  logic       acc_i;
  logic       acc_d;
  logic       force_i;
  logic [CNT_W-1:0] starve_cnt;

  assign req_i = is_active(i_htrans);
  assign req_d = is_active(d_htrans);

  ahb_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .acc_i      (acc_i),
    .acc_d      (acc_d),
    .force_i    (force_i),
    .starve_cnt (starve_cnt)
  );

  // A stalled address phase keeps its grant; otherwise LSU wins unless fetch is starved.
  always_comb begin
    gnt = park_q;
    if (lock_q) begin
      gnt = park_q;
    end else if (req_i && (force_i || !req_d)) begin
      gnt = MST_I;
    end else if (req_d) begin
      gnt = MST_D;
    end
  end

  assign gnt_i   = (gnt == MST_I);
  assign gnt_d   = (gnt == MST_D);
  assign gnt_act = gnt_d ? req_d : req_i;
  assign acc_i   = gnt_i & req_i & m_hready;
  assign acc_d   = gnt_d & req_d & m_hready;

  assign m_hmaster = gnt_d;
  assign m_haddr   = gnt_d ? d_haddr  : i_haddr;
  assign m_hsize   = gnt_d ? d_hsize  : i_hsize;
  assign m_hburst  = gnt_d ? d_hburst : i_hburst;
  assign m_hprot   = gnt_d ? d_hprot  : i_hprot;
  assign m_htrans  = gnt_act ? (gnt_d ? d_htrans : i_htrans) : HTRANS_IDLE;
  assign m_hwrite  = d_hwrite & gnt_d;
  assign m_hwdata  = (dp_owner == OWNER_D) ? d_hwdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      park_q   <= MST_I;
      lock_q   <= 1'b0;
      dp_owner <= OWNER_NONE;
    end else begin
      park_q <= gnt;
      lock_q <= m_hready ? 1'b0 : (lock_q | gnt_act);
      if (m_hready) begin
        if (!gnt_act) begin
          dp_owner <= OWNER_NONE;
        end else if (gnt_d) begin
          dp_owner <= OWNER_D;
        end else begin
          dp_owner <= OWNER_I;
        end
      end
    end
  end

  // A master that owns the data phase but also loses a new request must stall on both.
  always_comb begin
    if (dp_owner == OWNER_I) begin
      i_hready = m_hready & (~req_i | gnt_i);
    end else if (req_i) begin
      i_hready = gnt_i & m_hready;
    end else begin
      i_hready = 1'b1;
    end

    if (dp_owner == OWNER_D) begin
      d_hready = m_hready & (~req_d | gnt_d);
    end else if (req_d) begin
      d_hready = gnt_d & m_hready;
    end else begin
      d_hready = 1'b1;
    end
  end

  assign i_hrdata = (dp_owner == OWNER_I) ? m_hrdata : '0;
  assign d_hrdata = (dp_owner == OWNER_D) ? m_hrdata : '0;
  assign i_hresp  = (dp_owner == OWNER_I) ? m_hresp : HRESP_OKAY;
  assign d_hresp  = (dp_owner == OWNER_D) ? m_hresp : HRESP_OKAY;

endmodule
